// File: rtl/exp_arbiter_pkg.sv
// Shared fixed-point definitions for the exp sharing logic.
// Values are sign-magnitude Q16.15: bit 31 sign, [30:15] integer, [14:0] fraction.
package exp_arbiter_pkg;

    localparam int FIX_W  = 32;
    localparam int FRAC_W = 15;

    typedef logic [FIX_W-1:0] fix_t;

    localparam fix_t FIX_ONE = 32'h0000_8000;

    // Sign bit of a sign-magnitude fixed-point value.
    function automatic logic fix_sign(input fix_t v);
        return v[FIX_W-1];
    endfunction

endpackage

// File: rtl/exp_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per operand in flight in the exp unit.
// Push is ignored when full and pop is ignored when empty; a simultaneous push and
// pop leaves the occupancy unchanged while both pointers advance.
module exp_arbiter_tag_fifo
    import exp_arbiter_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_id,
    input  logic             pop,
    output logic [TAG_W-1:0] head_id,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualify the requests against the current occupancy flags.
    always_comb begin
        full      = (count_r == CNT_W'(DEPTH));
        empty     = (count_r == CNT_W'(0));
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        head_id   = mem_r[rd_ptr_r];
    end

    // Storage write; contents need no reset because count_r gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_id;
        end
    end

    // Pointer and occupancy bookkeeping; reset drops every stored tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Round-robin sharing of one exp unit among N requesters. Each issued operand's
// requester ID is queued in order; results coming back from the in-order exp unit
// are routed to the ID at the head of that queue. Data passes through untouched.
module exp_arbiter
    import exp_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int TAG_W = 2,
    parameter int DEPTH = 8,
    parameter int W     = FIX_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] req_x,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_rdy,
    output logic [W-1:0]   resp_y,
    output logic [N-1:0]   resp_valid,
    input  logic [N-1:0]   resp_rdy,
    output logic [W-1:0]   exp_x,
    output logic           exp_i_valid,
    input  logic           exp_o_rdy,
    input  logic [W-1:0]   exp_y,
    input  logic           exp_o_valid,
    output logic           exp_i_rdy,
    output logic           busy,
    output logic           err
);

    logic [TAG_W-1:0] ptr_r;
    logic             err_r;
    logic [TAG_W:0]   idx_s;
    logic             grant_found_s;
    logic [TAG_W-1:0] grant_id_s;
    logic             issue_s;
    logic             pop_s;
    logic             head_rdy_s;
    logic [TAG_W-1:0] head_id_s;
    logic             full_s;
    logic             empty_s;

    exp_arbiter_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue_s),
        .push_id (grant_id_s),
        .pop     (pop_s),
        .head_id (head_id_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Round-robin search starting at ptr_r; a full tag FIFO suppresses any grant,
    // even when a pop frees a slot in the same cycle, to keep the path short.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        idx_s         = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = {1'b0, ptr_r} + (TAG_W+1)'(i);
            if (idx_s >= (TAG_W+1)'(N)) begin
                idx_s = idx_s - (TAG_W+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_found_s && !full_s && req_valid[idx_s[TAG_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s[TAG_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        exp_i_valid = grant_found_s;
        issue_s     = grant_found_s && exp_o_rdy;
    end

    // Operand mux toward exp and the one-hot accept back to the granted lane.
    always_comb begin
        exp_x   = '0;
        req_rdy = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_found_s && (grant_id_s == TAG_W'(k))) begin
                exp_x      = req_x[k*W +: W];
                req_rdy[k] = issue_s;
            end else begin
                req_rdy[k] = 1'b0;
            end
        end
    end

    // Route the exp result to the requester at the head of the tag FIFO.
    always_comb begin
        resp_valid = '0;
        head_rdy_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (head_id_s == TAG_W'(k)) begin
                resp_valid[k] = exp_o_valid && !empty_s;
                head_rdy_s    = resp_rdy[k];
            end else begin
                resp_valid[k] = 1'b0;
            end
        end
        exp_i_rdy = !empty_s && head_rdy_s;
        pop_s     = exp_o_valid && exp_i_rdy;
        resp_y    = exp_y;
        busy      = !empty_s;
        err       = err_r;
    end

    // Advance the round-robin pointer past the lane that was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (issue_s) begin
            ptr_r <= (grant_id_s == TAG_W'(N - 1)) ? '0 : grant_id_s + TAG_W'(1);
        end
    end

    // Sticky flag for a result arriving with no tag to route it to.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (exp_o_valid && empty_s) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed bench for exp_arbiter with a small in-order exp unit model (latency LAT,
// elastic queue) and monitors recording issue and response handshakes.
module tb_exp_arbiter;

    localparam int N     = 4;
    localparam int TAG_W = 2;
    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int LAT   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] req_x = '0;
    logic [N-1:0]   req_valid = 4'b0000;
    logic [N-1:0]   resp_rdy = 4'b1111;
    logic           exp_o_rdy = 1'b1;
    logic           mdl_valid = 1'b0;
    logic [W-1:0]   mdl_y = 32'h0000_0000;
    logic           spur = 1'b0;
    wire  [N-1:0]   req_rdy;
    wire  [W-1:0]   resp_y;
    wire  [N-1:0]   resp_valid;
    wire  [W-1:0]   exp_x;
    wire            exp_i_valid;
    wire  [W-1:0]   exp_y;
    wire            exp_o_valid;
    wire            exp_i_rdy;
    wire            busy;
    wire            err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] x;
        int           t;
    } ent_t;
    typedef struct {
        logic [N-1:0] vec;
        logic [W-1:0] y;
    } rsp_t;

    ent_t         eq[$];
    logic [N-1:0] iss_q[$];
    rsp_t         rsp_q[$];
    logic [W-1:0] lane_x [N];

    assign exp_o_valid = mdl_valid | spur;
    assign exp_y       = spur ? 32'hDEAD_BEEF : mdl_y;

    exp_arbiter #(.N(N), .TAG_W(TAG_W), .DEPTH(DEPTH), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_x       (req_x),
        .req_valid   (req_valid),
        .req_rdy     (req_rdy),
        .resp_y      (resp_y),
        .resp_valid  (resp_valid),
        .resp_rdy    (resp_rdy),
        .exp_x       (exp_x),
        .exp_i_valid (exp_i_valid),
        .exp_o_rdy   (exp_o_rdy),
        .exp_y       (exp_y),
        .exp_o_valid (exp_o_valid),
        .exp_i_rdy   (exp_i_rdy),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Reference exp values for the operands used here; others get a distinct mapping.
    function automatic logic [W-1:0] exp_f(input logic [W-1:0] x);
        case (x)
            32'h0000_0000: return 32'h0000_8000;
            32'h0000_8000: return 32'h0001_5BF1;
            default:       return x ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // In-order exp unit model: accepts when fewer than 16 are held, result after LAT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            eq.delete();
            mdl_valid <= 1'b0;
            mdl_y     <= 32'h0000_0000;
            exp_o_rdy <= 1'b1;
        end else begin
            if (mdl_valid && exp_i_rdy) begin
                void'(eq.pop_front());
            end
            if (exp_i_valid && exp_o_rdy) begin
                eq.push_back('{x: exp_x, t: cyc});
            end
            if (eq.size() > 0 && (eq[0].t + LAT) <= (cyc + 1)) begin
                mdl_valid <= 1'b1;
                mdl_y     <= exp_f(eq[0].x);
            end else begin
                mdl_valid <= 1'b0;
                mdl_y     <= 32'h0000_0000;
            end
            exp_o_rdy <= (eq.size() < 16);
        end
    end

    // Record every issue and every delivered response.
    always @(posedge clk) begin
        if (!rst) begin
            if (|req_rdy) begin
                iss_q.push_back(req_rdy);
            end
            if (|(resp_valid & resp_rdy)) begin
                rsp_q.push_back('{vec: resp_valid, y: resp_y});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        spur      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        iss_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_resp(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (|resp_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state
        do_reset();
        #1;
        check("rst_req_rdy",    32'(req_rdy),     32'd0);
        check("rst_resp_valid", 32'(resp_valid),  32'd0);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_err",        32'(err),         32'd0);
        check("rst_exp_ivalid", 32'(exp_i_valid), 32'd0);
        check("rst_exp_irdy",   32'(exp_i_rdy),   32'd0);

        // Test 2: single lane, exp(0)=1.0 then exp(1.0)=e
        resp_rdy       = 4'b1111;
        req_x[31:0]    = 32'h0000_0000;
        req_valid      = 4'b0001;
        #1;
        check("t2_req_rdy",   32'(req_rdy),     32'd1);
        check("t2_exp_valid", 32'(exp_i_valid), 32'd1);
        check("t2_exp_x",     exp_x,            32'h0000_0000);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_resp("t2_wait_one");
        check("t2_resp_valid_one", 32'(resp_valid), 32'd1);
        check("t2_resp_y_one",     resp_y,          32'h0000_8000);
        check("t2_busy_one",       32'(busy),       32'd1);
        @(negedge clk);
        #1;
        check("t2_busy_drained", 32'(busy), 32'd0);
        req_x[31:0] = 32'h0000_8000;
        req_valid   = 4'b0001;
        #1;
        check("t2_req_rdy_e", 32'(req_rdy), 32'd1);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_resp("t2_wait_e");
        check("t2_resp_valid_e", 32'(resp_valid), 32'd1);
        check("t2_resp_y_e",     resp_y,          32'h0001_5BF1);

        // Test 3: fairness, all lanes requesting continuously
        do_reset();
        lane_x[0] = 32'h1100_0000;
        lane_x[1] = 32'h2200_0001;
        lane_x[2] = 32'h3300_0002;
        lane_x[3] = 32'h4400_0003;
        req_x     = {lane_x[3], lane_x[2], lane_x[1], lane_x[0]};
        req_valid = 4'b1111;
        repeat (12) @(negedge clk);
        req_valid = 4'b0000;
        repeat (10) @(negedge clk);
        check("t3_issue_count", 32'(iss_q.size()), 32'd12);
        check("t3_resp_count",  32'(rsp_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < iss_q.size()) begin
                check("t3_grant_order", 32'(iss_q[i]), 32'd1 << (i % 4));
            end
            if (i < rsp_q.size()) begin
                check("t3_resp_lane", 32'(rsp_q[i].vec), 32'd1 << (i % 4));
                check("t3_resp_y",    rsp_q[i].y,        exp_f(lane_x[i % 4]));
            end
        end

        // Test 4: backpressure fills the tag FIFO, then drains in order
        do_reset();
        resp_rdy = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            req_x[31:0] = 32'h0ABC_0000 + 32'(iss_q.size());
            req_valid   = 4'b0001;
            @(negedge clk);
        end
        #1;
        check("t4_issued_depth", 32'(iss_q.size()), 32'(DEPTH));
        check("t4_busy",         32'(busy),         32'd1);
        check("t4_stall_rdy",    32'(req_rdy),      32'd0);
        check("t4_stall_valid",  32'(exp_i_valid),  32'd0);
        check("t4_head_waiting", 32'(resp_valid),   32'd1);
        resp_rdy = 4'b1111;
        #1;
        check("t4_pop_irdy",       32'(exp_i_rdy),   32'd1);
        check("t4_full_pop_rdy",   32'(req_rdy),     32'd0);
        check("t4_full_pop_valid", 32'(exp_i_valid), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (20) @(negedge clk);
        check("t4_issue_total", 32'(iss_q.size()), 32'(DEPTH));
        check("t4_resp_total",  32'(rsp_q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (i < rsp_q.size()) begin
                check("t4_resp_lane", 32'(rsp_q[i].vec), 32'd1);
                check("t4_resp_y",    rsp_q[i].y,        exp_f(32'h0ABC_0000 + 32'(i)));
            end
        end
        #1;
        check("t4_busy_end", 32'(busy), 32'd0);

        // Test 5: reset with three operands in flight
        do_reset();
        resp_rdy  = 4'b0000;
        req_x     = {lane_x[3], lane_x[2], lane_x[1], lane_x[0]};
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("t5_in_flight", 32'(iss_q.size()), 32'd3);
        check("t5_busy_pre",  32'(busy),         32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t5_busy_post",  32'(busy),       32'd0);
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        rst      = 1'b0;
        resp_rdy = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("t5_no_stale", 32'(resp_valid), 32'd0);
        end
        check("t5_no_resp", 32'(rsp_q.size()), 32'd0);

        // Test 6: spurious result with empty FIFO
        do_reset();
        spur = 1'b1;
        #1;
        check("t6_resp_valid", 32'(resp_valid), 32'd0);
        check("t6_exp_irdy",   32'(exp_i_rdy),  32'd0);
        check("t6_err_before", 32'(err),        32'd0);
        @(negedge clk);
        spur = 1'b0;
        #1;
        check("t6_err_set", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("t6_err_sticky",  32'(err),        32'd1);
        check("t6_resp_quiet",  32'(resp_valid), 32'd0);
        do_reset();
        #1;
        check("t6_err_cleared", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
